// File: rtl/alu_exec_stage_pkg.sv
// Shared processor constants: ALU operation codes and exec-stage buffer states.
// Also used by the ALU control decoder, so codes here are the architectural encoding.
package alu_exec_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

  localparam int RD_W = 5;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Pure combinational ALU datapath; unsupported codes yield result 0 with illegal set.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = '0;
    endcase
  end

  assign zero    = (result == '0);
  assign illegal = !op_is_legal(alu_control);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one output register plus one skid register behind a
// registered in_ready, so upstream ready never depends combinationally on out_ready.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [RD_W-1:0]  rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [RD_W-1:0]  rd_out
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [RD_W-1:0]  rd;
  } entry_t;

  localparam entry_t OUT_RST = '{result: '0, zero: 1'b1, illegal: 1'b0, rd: '0};

  stage_state_e state_q, state_d;
  entry_t       out_q, skid_q, new_e;
  logic         in_ready_q;
  logic         accept, consume;
  logic         load_out, load_skid, pop_skid;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (new_e.result),
    .zero        (new_e.zero),
    .illegal     (new_e.illegal)
  );
  assign new_e.rd = rd_in;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
        ST_ONE: begin
          if (accept && !consume) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (!accept && consume) begin
            state_d = ST_EMPTY;
          end else if (accept && consume) begin
            load_out = 1'b1;
          end
        end
        // in_ready is low here, so only the skid drain can happen
        ST_TWO: if (consume) begin
          state_d  = ST_ONE;
          pop_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Data registers keep their contents on flush; only the state empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= OUT_RST;
      skid_q <= '0;
    end else begin
      if (load_out)      out_q <= new_e;
      else if (pop_skid) out_q <= skid_q;
      if (load_skid)     skid_q <= new_e;
    end
  end

  assign result  = out_q.result;
  assign zero    = out_q.zero;
  assign illegal = out_q.illegal;
  assign rd_out  = out_q.rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  rd_out;

  int n_chk;
  int n_fail;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .rd_in       (rd_in),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal),
    .rd_out      (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for exactly one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    rd_in       = rd;
    tick();
    in_valid    = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; in_valid = 1'b0; alu_control = 3'b000; src_a = '0; src_b = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'b0, zero},      32'd1);
    chk("rst_illegal",   {31'b0, illegal},   32'd0);
    chk("rst_rd_out",    {27'b0, rd_out},    32'd0);
    rst = 1'b1;
    tick();

    // basic ops, back-to-back with out_ready held high
    out_ready = 1'b1;
    issue(3'b000, 32'd5, 32'd7, 5'd3);
    chk("add_valid",  {31'b0, out_valid}, 32'd1);
    chk("add_result", result,             32'd12);
    chk("add_zero",   {31'b0, zero},      32'd0);
    chk("add_rd",     {27'b0, rd_out},    32'd3);
    chk("add_illegal",{31'b0, illegal},   32'd0);
    issue(3'b001, 32'd0, 32'd1, 5'd4);
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    chk("sub_wrap_rd", {27'b0, rd_out}, 32'd4);
    issue(3'b001, 32'd9, 32'd9, 5'd5);
    chk("sub_eq_result", result, 32'd0);
    chk("sub_eq_zero", {31'b0, zero}, 32'd1);
    issue(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd6);
    chk("add_wrap", result, 32'd1);
    issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd7);
    chk("and", result, 32'h0000_F000);
    issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00, 5'd8);
    chk("or", result, 32'h0000_FFF0);
    issue(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd9);
    chk("slt_neg_lt", result, 32'd1);
    issue(3'b101, 32'd1, 32'hFFFF_FFFF, 5'd10);
    chk("slt_pos_ge", result, 32'd0);
    chk("slt_zero", {31'b0, zero}, 32'd1);
    issue(3'b111, 32'd3, 32'd4, 5'd11);
    chk("ill7_result",  result,           32'd0);
    chk("ill7_zero",    {31'b0, zero},    32'd1);
    chk("ill7_illegal", {31'b0, illegal}, 32'd1);
    issue(3'b100, 32'd3, 32'd4, 5'd12);
    chk("ill4_illegal", {31'b0, illegal}, 32'd1);
    issue(3'b000, 32'd1, 32'd1, 5'd13);
    chk("legal_after_ill", {31'b0, illegal}, 32'd0);
    tick();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // backpressure: fill output + skid, then drain in order
    out_ready = 1'b0;
    issue(3'b000, 32'd2, 32'd2, 5'd1);
    chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp1_result", result, 32'd4);
    issue(3'b000, 32'd3, 32'd3, 5'd2);
    chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp2_result_hold", result, 32'd4);
    chk("bp2_rd_hold", {27'b0, rd_out}, 32'd1);
    tick();
    chk("bp_stall_result", result, 32'd4);
    chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_result", result, 32'd6);
    chk("bp_drain1_rd", {27'b0, rd_out}, 32'd2);
    chk("bp_drain1_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_drain2_empty", {31'b0, out_valid}, 32'd0);

    // flush in TWO with a coincident offer and consume
    out_ready = 1'b0;
    issue(3'b000, 32'd10, 32'd0, 5'd14);
    issue(3'b000, 32'd20, 32'd0, 5'd15);
    chk("fl_two_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    issue(3'b000, 32'd30, 32'd0, 5'd16);
    flush = 1'b0;
    chk("fl_two_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_two_in_ready_after", {31'b0, in_ready}, 32'd1);
    repeat (3) begin
      tick();
      chk("fl_two_stays_empty", {31'b0, out_valid}, 32'd0);
    end
    issue(3'b000, 32'd40, 32'd0, 5'd17);
    chk("fl_two_next_result", result, 32'd40);
    chk("fl_two_next_rd", {27'b0, rd_out}, 32'd17);
    tick();

    // flush in ONE discards a simultaneously accepted op
    out_ready = 1'b0;
    issue(3'b000, 32'd50, 32'd0, 5'd18);
    flush = 1'b1;
    issue(3'b000, 32'd60, 32'd0, 5'd19);
    flush = 1'b0;
    chk("fl_one_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_one_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_one_no_ghost", {31'b0, out_valid}, 32'd0);

    // async reset while in TWO, observed before the next edge
    out_ready = 1'b0;
    issue(3'b000, 32'd70, 32'd0, 5'd20);
    issue(3'b000, 32'd80, 32'd0, 5'd21);
    chk("ar_two_in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'b0, in_ready},  32'd1);
    chk("ar_result",    result,             32'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    issue(3'b001, 32'd100, 32'd1, 5'd22);
    chk("ar_first_valid", {31'b0, out_valid}, 32'd1);
    chk("ar_first_result", result, 32'd99);
    tick();
    chk("ar_no_stale", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
